hnsn_core: RTL and testbench
============================

# hnsn_core

Top of the hybrid neuromorphic spiking network (HNSN) block, ports matching `hnsn_top`. Contains four recurrent leaky integrate-and-fire (LIF) neurons paired into two assemblies (A = N0/N1, B = N2/N3) with dopamine-gated Hebbian plasticity, plus one output neuron. Also decodes the active assembly into an ASCII character. Sits between the spike-encoding front end and the host readout.

## Interface
- `V_TH`, 100: firing threshold, all neurons.
- `EXT_W`, 40: input added per external spike.
- `W_INIT`, 8: reset value of recurrent weights.
- `W_MAX`, 120: recurrent weight ceiling.
- `SYN_INIT`, 30: reset value of output synapse.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `ext_spike_in` in 4: external spike per neuron N0..N3.
- `reward` in 1: reward level.
- `char_out` out 8: decoded ASCII character.
- `char_valid` out 1: any recurrent spike this cycle.
- `char_changed` out 1: one-cycle pulse when `char_out` changes.
- `rec_spike` out 4: recurrent neuron spikes.
- `output_spike` out 1: output neuron spike.
- `dopamine` out 2: dopamine level.
- `syn_weight` out 8: output synapse weight.
- `v_out` out 8: output neuron membrane.

## Operation
- Reset values:
  - `v_mem_*`, `v_out`, `rec_spike`, `output_spike`, `dopamine`, `char_valid`, `char_changed` = 0.
  - All four recurrent weights = `W_INIT`.
  - `syn_weight` = `SYN_INIT`.
  - `char_out` = 0x2D ('-').
- Dopamine:
  - `reward`=1: increment, saturating at 3.
  - `reward`=0: decrement, saturating at 0.
- Recurrent neuron i, per cycle:
  - Sum = v − (v>>3) + (ext[i] ? `EXT_W` : 0) + (partner spiked previous cycle ? w_partner→i : 0).
  - Compute the sum in 10 bits and saturate to 255.
  - Partners: N0↔N1 via w01 (N0→N1) and w10 (N1→N0); N2↔N3 via w23 and w32.
  - If sum ≥ `V_TH`: spike = 1 and v = 0. Otherwise spike = 0 and v = sum.
  - Spikes are registered and are the `rec_spike` output.
- Plasticity for w_pre→post:
  - Condition: post spikes this cycle, pre spiked this or the previous cycle, and `dopamine` ≠ 0.
  - Update: w += `dopamine`, clamped at `W_MAX`.
  - No change otherwise.
  - Weights never cross between assemblies.
- Output neuron:
  - v_out' = v_out − (v_out>>3) + (`rec_spike` ≠ 0 ? `syn_weight` : 0), saturated.
  - Threshold and reset as the recurrent neurons.
- Output synapse: on `output_spike` with `dopamine` ≠ 0, `syn_weight` += `dopamine`, saturating at 255.
- Character decode, registered:
  - A active (N0|N1) and B inactive: 'A' (0x41).
  - B active (N2|N3) and A inactive: 'B' (0x42).
  - Both active: 'X' (0x58).
  - Neither active: hold the previous value.
- `char_changed` = 1 for exactly the cycle in which the new `char_out` value first appears.

## Timing
- Inputs are sampled at edge t. Resulting `v_mem`, `rec_spike` and `dopamine` are visible after edge t.
- Recurrent coupling latency is one cycle: a partner spike at t contributes at t+1.
- The output neuron sees `rec_spike` from the previous cycle, so `output_spike` lags by one cycle.
- `char_out` and `char_valid` lag `rec_spike` by one cycle.
- Weight updates use the `dopamine` value registered before the current edge.
- `rst` asserted mid-run restores all reset values at the next edge, including learned weights.
- Constant `ext_spike_in` bit with no partner drive fires every 3rd cycle: membrane 40, 75, 106 → spike.

## Configuration
- `HNSN_WEIGHT_DECAY_EN` defined:
  - A 6-bit free-running counter runs continuously.
  - On wrap, while `dopamine` = 0, every recurrent weight above `W_INIT` decrements by 1.
- Macro undefined: weights change only via plasticity.

## Structure
- Package `hnsn_pkg` holds:
  - Parameter defaults.
  - ASCII constants (`CH_NONE`, `CH_A`, `CH_B`, `CH_BOTH`).
  - A saturating-add helper function.
- Sub-module `recurrent_layer`, instance `rec_layer`:
  - Contains the four neurons, the four weights, the plasticity logic and the decay option.
  - Must expose the signals `w01`, `w10`, `w23`, `w32`, `v_mem_0`..`v_mem_3` under these exact names; benches probe them hierarchically.
- Dopamine counter, output neuron and char decoder live in the top.

## Test plan
- Reset → all outputs 0, weights 8, `syn_weight` 30, `char_out` '-', `dopamine` 0.
- `ext`=0001, `reward`=0 for 30 cycles:
  - N0 spikes every 3rd cycle (10 spikes); N1–N3 silent.
  - `char_out`='A'; weights unchanged.
- `reward`=1 for 4 cycles, then 0 → `dopamine` 1, 2, 3, 3, then 2, 1, 0.
- `ext`=0011, `reward`=1 for 120 cycles:
  - w01 and w10 reach 120; w23 and w32 stay 8.
  - Then 30 idle cycles, then `ext`=0001 for 100 cycles: N1 spike count within ±1 of N0; N2 and N3 count 0.
- Same procedure with `ext`=1100 → w23 and w32 reach 120. Then `ext`=0100 recruits N3, and `char_out` becomes 'B' with a single `char_changed` pulse.
- With `HNSN_WEIGHT_DECAY_EN`: after learning, 64×k idle cycles lower each learned weight by k, and no weight drops below 8.

Source files
------------

// File: rtl/hnsn_pkg.sv
// hnsn_pkg: shared constants and arithmetic helpers for the HNSN core.
// Holds default neuron/synapse parameters, decoded ASCII codes and the
// leaky-integrate saturating sum used by every LIF neuron in the block.
package hnsn_pkg;

  localparam logic [7:0] V_TH_DEF     = 8'd100;
  localparam logic [7:0] EXT_W_DEF    = 8'd40;
  localparam logic [7:0] W_INIT_DEF   = 8'd8;
  localparam logic [7:0] W_MAX_DEF    = 8'd120;
  localparam logic [7:0] SYN_INIT_DEF = 8'd30;

  localparam logic [7:0] CH_NONE = 8'h2D;  // '-'
  localparam logic [7:0] CH_A    = 8'h41;  // 'A'
  localparam logic [7:0] CH_B    = 8'h42;  // 'B'
  localparam logic [7:0] CH_BOTH = 8'h58;  // 'X'

  // Saturate a 10-bit intermediate sum to 8 bits.
  function automatic logic [7:0] sat8(input logic [9:0] s);
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  // v - v/8 + a + b, computed in 10 bits so nothing wraps, then saturated.
  function automatic logic [7:0] leak_add(input logic [7:0] v,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [9:0] s;
    s = {2'b00, v} - {5'b00000, v[7:3]} + {2'b00, a} + {2'b00, b};
    return sat8(s);
  endfunction

endpackage

// File: rtl/recurrent_layer.sv
// recurrent_layer: four recurrent LIF neurons in two pairs (N0/N1, N2/N3),
// the four intra-pair weights and dopamine-gated Hebbian plasticity.
// Ports: clk, rst (sync, active-high), ext_spike_in[3:0], dopamine[1:0]
// (registered level), rec_spike[3:0], weights w01/w10/w23/w32, v_mem_0..3.
// Optional HNSN_WEIGHT_DECAY_EN: weights above W_INIT decay by 1 every 64
// cycles while dopamine is zero.
module recurrent_layer
  import hnsn_pkg::*;
#(
  parameter logic [7:0] V_TH   = V_TH_DEF,
  parameter logic [7:0] EXT_W  = EXT_W_DEF,
  parameter logic [7:0] W_INIT = W_INIT_DEF,
  parameter logic [7:0] W_MAX  = W_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ext_spike_in,
  input  logic [1:0] dopamine,
  output logic [3:0] rec_spike,
  output logic [7:0] w01,
  output logic [7:0] w10,
  output logic [7:0] w23,
  output logic [7:0] w32,
  output logic [7:0] v_mem_0,
  output logic [7:0] v_mem_1,
  output logic [7:0] v_mem_2,
  output logic [7:0] v_mem_3
);

  // win_q[i] is the weight onto neuron i from its partner (i^1), so the
  // pairing alone keeps weights from ever crossing between assemblies.
  logic [7:0] v_q   [4];
  logic [7:0] v_d   [4];
  logic [7:0] win_q [4];
  logic [7:0] win_d [4];
  logic [7:0] sum   [4];
  logic [8:0] wsum  [4];
  logic [3:0] spike_q;
  logic [3:0] spike_d;

`ifdef HNSN_WEIGHT_DECAY_EN
  logic [5:0] decay_cnt_q;
  logic [5:0] decay_cnt_d;
  logic       decay_tick;

  assign decay_cnt_d = decay_cnt_q + 6'd1;
  assign decay_tick  = (decay_cnt_q == 6'h3F) && (dopamine == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) decay_cnt_q <= '0;
    else     decay_cnt_q <= decay_cnt_d;
  end
`endif

  always_comb begin
    v_d     = v_q;
    win_d   = win_q;
    spike_d = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = leak_add(v_q[i],
                        ext_spike_in[i] ? EXT_W : 8'd0,
                        spike_q[i ^ 1] ? win_q[i] : 8'd0);
      spike_d[i] = (sum[i] >= V_TH);
      v_d[i]     = spike_d[i] ? 8'd0 : sum[i];
    end
    // Plasticity needs this cycle's spikes of both neurons, so it runs
    // after every neuron has been evaluated.
    for (int i = 0; i < 4; i++) begin
      wsum[i] = {1'b0, win_q[i]} + {7'b0000000, dopamine};
      if (spike_d[i] && (spike_d[i ^ 1] || spike_q[i ^ 1]) && (dopamine != 2'd0)) begin
        win_d[i] = (wsum[i] > {1'b0, W_MAX}) ? W_MAX : wsum[i][7:0];
      end
`ifdef HNSN_WEIGHT_DECAY_EN
      // Disjoint from plasticity: decay only fires when dopamine is zero.
      else if (decay_tick && (win_q[i] > W_INIT)) begin
        win_d[i] = win_q[i] - 8'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= '0;
      for (int i = 0; i < 4; i++) begin
        v_q[i]   <= '0;
        win_q[i] <= W_INIT;
      end
    end else begin
      spike_q <= spike_d;
      v_q     <= v_d;
      win_q   <= win_d;
    end
  end

  assign rec_spike = spike_q;
  assign w01       = win_q[1];
  assign w10       = win_q[0];
  assign w23       = win_q[3];
  assign w32       = win_q[2];
  assign v_mem_0   = v_q[0];
  assign v_mem_1   = v_q[1];
  assign v_mem_2   = v_q[2];
  assign v_mem_3   = v_q[3];

endmodule

// File: rtl/hnsn_core.sv
// hnsn_core: HNSN top - recurrent layer, dopamine counter, output neuron
// and assembly-to-ASCII decoder.
// Ports: clk, rst (sync, active-high), ext_spike_in[3:0], reward in;
// char_out/char_valid/char_changed, rec_spike, output_spike, dopamine,
// syn_weight, v_out out. Macro HNSN_WEIGHT_DECAY_EN enables weight decay.
module hnsn_core
  import hnsn_pkg::*;
#(
  parameter logic [7:0] V_TH     = V_TH_DEF,
  parameter logic [7:0] EXT_W    = EXT_W_DEF,
  parameter logic [7:0] W_INIT   = W_INIT_DEF,
  parameter logic [7:0] W_MAX    = W_MAX_DEF,
  parameter logic [7:0] SYN_INIT = SYN_INIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ext_spike_in,
  input  logic       reward,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       char_changed,
  output logic [3:0] rec_spike,
  output logic       output_spike,
  output logic [1:0] dopamine,
  output logic [7:0] syn_weight,
  output logic [7:0] v_out
);

  logic [1:0] dopamine_q, dopamine_d;
  logic [7:0] v_out_q, v_out_d, vo_sum;
  logic       out_spike_q, out_spike_d;
  logic [7:0] syn_q, syn_d;
  logic [7:0] char_q, char_d;
  logic       valid_q, valid_d;
  logic       changed_q, changed_d;
  logic       a_act, b_act;
  logic [7:0] w01, w10, w23, w32;
  logic [7:0] v_mem_0, v_mem_1, v_mem_2, v_mem_3;

  // The layer sees the dopamine level registered before the current edge.
  recurrent_layer #(
    .V_TH   (V_TH),
    .EXT_W  (EXT_W),
    .W_INIT (W_INIT),
    .W_MAX  (W_MAX)
  ) rec_layer (
    .clk          (clk),
    .rst          (rst),
    .ext_spike_in (ext_spike_in),
    .dopamine     (dopamine_q),
    .rec_spike    (rec_spike),
    .w01          (w01),
    .w10          (w10),
    .w23          (w23),
    .w32          (w32),
    .v_mem_0      (v_mem_0),
    .v_mem_1      (v_mem_1),
    .v_mem_2      (v_mem_2),
    .v_mem_3      (v_mem_3)
  );

  assign a_act = |rec_spike[1:0];
  assign b_act = |rec_spike[3:2];

  always_comb begin
    dopamine_d = dopamine_q;
    if (reward) begin
      if (dopamine_q != 2'd3) dopamine_d = dopamine_q + 2'd1;
    end else begin
      if (dopamine_q != 2'd0) dopamine_d = dopamine_q - 2'd1;
    end

    // Output neuron integrates the registered (previous-cycle) spikes.
    vo_sum      = leak_add(v_out_q, (rec_spike != 4'd0) ? syn_q : 8'd0, 8'd0);
    out_spike_d = (vo_sum >= V_TH);
    v_out_d     = out_spike_d ? 8'd0 : vo_sum;

    syn_d = syn_q;
    if (out_spike_d && (dopamine_q != 2'd0)) begin
      syn_d = sat8({2'b00, syn_q} + {8'h00, dopamine_q});
    end

    case ({b_act, a_act})
      2'b01:   char_d = CH_A;
      2'b10:   char_d = CH_B;
      2'b11:   char_d = CH_BOTH;
      default: char_d = char_q;
    endcase
    valid_d   = a_act | b_act;
    changed_d = (char_d != char_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dopamine_q  <= '0;
      v_out_q     <= '0;
      out_spike_q <= 1'b0;
      syn_q       <= SYN_INIT;
      char_q      <= CH_NONE;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      dopamine_q  <= dopamine_d;
      v_out_q     <= v_out_d;
      out_spike_q <= out_spike_d;
      syn_q       <= syn_d;
      char_q      <= char_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
    end
  end

  assign dopamine     = dopamine_q;
  assign v_out        = v_out_q;
  assign output_spike = out_spike_q;
  assign syn_weight   = syn_q;
  assign char_out     = char_q;
  assign char_valid   = valid_q;
  assign char_changed = changed_q;

endmodule

// File: tb/tb_hnsn_core.sv
module tb_hnsn_core;

  logic       clk;
  logic       rst;
  logic [3:0] ext_spike_in;
  logic       reward;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_changed;
  logic [3:0] rec_spike;
  logic       output_spike;
  logic [1:0] dopamine;
  logic [7:0] syn_weight;
  logic [7:0] v_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] spk;
    logic [7:0] vo;
    bit         vo_chk;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] dop_q[$];

  hnsn_core dut (
    .clk          (clk),
    .rst          (rst),
    .ext_spike_in (ext_spike_in),
    .reward       (reward),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_changed (char_changed),
    .rec_spike    (rec_spike),
    .output_spike (output_spike),
    .dopamine     (dopamine),
    .syn_weight   (syn_weight),
    .v_out        (v_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ext_spike_in = 4'b0000; reward = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_spike_in = 4'b0000; reward = 1'b0;
    step(); step();
    checks++; if (char_out !== 8'h2D) begin errors++; $display("FAIL reset_char got=%h exp=2d", char_out); end
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", char_valid); end
    checks++; if (char_changed !== 1'b0) begin errors++; $display("FAIL reset_changed got=%b exp=0", char_changed); end
    checks++; if (rec_spike !== 4'h0) begin errors++; $display("FAIL reset_rec_spike got=%b exp=0000", rec_spike); end
    checks++; if (output_spike !== 1'b0) begin errors++; $display("FAIL reset_out_spike got=%b exp=0", output_spike); end
    checks++; if (dopamine !== 2'd0) begin errors++; $display("FAIL reset_dopamine got=%0d exp=0", dopamine); end
    checks++; if (syn_weight !== 8'd30) begin errors++; $display("FAIL reset_syn got=%0d exp=30", syn_weight); end
    checks++; if (v_out !== 8'd0) begin errors++; $display("FAIL reset_v_out got=%0d exp=0", v_out); end
    checks++; if (dut.rec_layer.v_mem_0 !== 8'd0) begin errors++; $display("FAIL reset_v_mem_0 got=%0d exp=0", dut.rec_layer.v_mem_0); end
    checks++; if ({dut.rec_layer.w01, dut.rec_layer.w10, dut.rec_layer.w23, dut.rec_layer.w32} !== {4{8'd8}})
      begin errors++; $display("FAIL reset_weights got=%0d,%0d,%0d,%0d exp=8,8,8,8", dut.rec_layer.w01, dut.rec_layer.w10, dut.rec_layer.w23, dut.rec_layer.w32); end
    rst = 1'b0;
  endtask

  // N0 alone: membrane 40, 75, 106 -> spike every 3rd edge. The output
  // neuron integrates syn_weight=30 one edge after each rec spike.
  task automatic test_single_neuron();
    logic [7:0] vo_tab [10];
    exp_t e;
    int   n_changed;
    vo_tab = '{8'd0, 8'd0, 8'd0, 8'd30, 8'd27, 8'd24, 8'd51, 8'd45, 8'd40, 8'd65};
    n_changed = 0;
    do_reset();
    ext_spike_in = 4'b0001; reward = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      e.spk    = (k % 3 == 0) ? 4'b0001 : 4'b0000;
      e.vo     = (k <= 10) ? vo_tab[k-1] : 8'd0;
      e.vo_chk = (k <= 10);
      exp_q.push_back(e);
      step();
      e = exp_q.pop_front();
      checks++; if (rec_spike !== e.spk) begin errors++; $display("FAIL single_spike[%0d] got=%b exp=%b", k, rec_spike, e.spk); end
      if (e.vo_chk) begin
        checks++; if (v_out !== e.vo) begin errors++; $display("FAIL single_v_out[%0d] got=%0d exp=%0d", k, v_out, e.vo); end
      end
      if (k == 1) begin
        checks++; if (dut.rec_layer.v_mem_0 !== 8'd40) begin errors++; $display("FAIL v_mem_0_e1 got=%0d exp=40", dut.rec_layer.v_mem_0); end
      end
      if (k == 2) begin
        checks++; if (dut.rec_layer.v_mem_0 !== 8'd75) begin errors++; $display("FAIL v_mem_0_e2 got=%0d exp=75", dut.rec_layer.v_mem_0); end
      end
      if (char_changed) n_changed++;
    end
    ext_spike_in = 4'b0000;
    step();
    if (char_changed) n_changed++;
    checks++; if (char_out !== 8'h41) begin errors++; $display("FAIL single_char got=%h exp=41", char_out); end
    checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", char_valid); end
    checks++; if (n_changed != 1) begin errors++; $display("FAIL single_changed_pulses got=%0d exp=1", n_changed); end
    checks++; if ({dut.rec_layer.w01, dut.rec_layer.w10, dut.rec_layer.w23, dut.rec_layer.w32} !== {4{8'd8}})
      begin errors++; $display("FAIL single_weights got=%0d,%0d,%0d,%0d exp=8,8,8,8", dut.rec_layer.w01, dut.rec_layer.w10, dut.rec_layer.w23, dut.rec_layer.w32); end
  endtask

  task automatic test_dopamine();
    logic [1:0] dop_tab [7];
    logic [1:0] d;
    dop_tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    ext_spike_in = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      reward = (k < 4);
      dop_q.push_back(dop_tab[k]);
      step();
      d = dop_q.pop_front();
      checks++; if (dopamine !== d) begin errors++; $display("FAIL dopamine[%0d] got=%0d exp=%0d", k, dopamine, d); end
    end
    reward = 1'b0;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    ext_spike_in = 4'b0011; reward = 1'b1;
    repeat (60) step();
    checks++; if (!(dut.rec_layer.w01 > 8'd8)) begin errors++; $display("FAIL midrun_learned got=%0d exp=>8", dut.rec_layer.w01); end
    rst = 1'b1;
    step();
    checks++; if ({dut.rec_layer.w01, dut.rec_layer.w10} !== {8'd8, 8'd8}) begin errors++; $display("FAIL midrun_weights got=%0d,%0d exp=8,8", dut.rec_layer.w01, dut.rec_layer.w10); end
    checks++; if (dopamine !== 2'd0) begin errors++; $display("FAIL midrun_dopamine got=%0d exp=0", dopamine); end
    checks++; if (rec_spike !== 4'b0000) begin errors++; $display("FAIL midrun_rec_spike got=%b exp=0000", rec_spike); end
    checks++; if (char_out !== 8'h2D) begin errors++; $display("FAIL midrun_char got=%h exp=2d", char_out); end
    checks++; if (syn_weight !== 8'd30) begin errors++; $display("FAIL midrun_syn got=%0d exp=30", syn_weight); end
    rst = 1'b0;
  endtask

  task automatic test_learn_a();
    int n [4];
    do_reset();
    ext_spike_in = 4'b0011; reward = 1'b1;
    repeat (120) step();
    checks++; if ({dut.rec_layer.w01, dut.rec_layer.w10} !== {8'd120, 8'd120}) begin errors++; $display("FAIL learn_a_w got=%0d,%0d exp=120,120", dut.rec_layer.w01, dut.rec_layer.w10); end
    checks++; if ({dut.rec_layer.w23, dut.rec_layer.w32} !== {8'd8, 8'd8}) begin errors++; $display("FAIL learn_a_wb got=%0d,%0d exp=8,8", dut.rec_layer.w23, dut.rec_layer.w32); end
    ext_spike_in = 4'b0000; reward = 1'b0;
    repeat (30) step();
`ifndef HNSN_WEIGHT_DECAY_EN
    checks++; if (dut.rec_layer.w01 !== 8'd120) begin errors++; $display("FAIL learn_a_hold got=%0d exp=120", dut.rec_layer.w01); end
`endif
    n = '{0, 0, 0, 0};
    ext_spike_in = 4'b0001;
    for (int k = 0; k < 100; k++) begin
      step();
      for (int j = 0; j < 4; j++) if (rec_spike[j]) n[j]++;
    end
    ext_spike_in = 4'b0000;
    checks++; if (n[0] < 30) begin errors++; $display("FAIL recall_a_n0 got=%0d exp=>=30", n[0]); end
    checks++; if ((n[1] > n[0] + 1) || (n[1] + 1 < n[0])) begin errors++; $display("FAIL recall_a_n1 got=%0d exp=%0d+-1", n[1], n[0]); end
    checks++; if ((n[2] != 0) || (n[3] != 0)) begin errors++; $display("FAIL recall_a_b_silent got=%0d,%0d exp=0,0", n[2], n[3]); end
`ifdef HNSN_WEIGHT_DECAY_EN
    begin
      logic [7:0] w0;
      w0 = dut.rec_layer.w01;
      repeat (64 * 3) step();
      checks++; if (dut.rec_layer.w01 !== w0 - 8'd3) begin errors++; $display("FAIL decay_k3 got=%0d exp=%0d", dut.rec_layer.w01, w0 - 8'd3); end
      repeat (64 * 120) step();
      checks++; if ({dut.rec_layer.w01, dut.rec_layer.w10} !== {8'd8, 8'd8}) begin errors++; $display("FAIL decay_floor got=%0d,%0d exp=8,8", dut.rec_layer.w01, dut.rec_layer.w10); end
    end
`endif
  endtask

  task automatic test_learn_b();
    int n [4];
    int n_changed;
    n_changed = 0;
    do_reset();
    ext_spike_in = 4'b1100; reward = 1'b1;
    for (int k = 0; k < 120; k++) begin step(); if (char_changed) n_changed++; end
    checks++; if ({dut.rec_layer.w23, dut.rec_layer.w32} !== {8'd120, 8'd120}) begin errors++; $display("FAIL learn_b_w got=%0d,%0d exp=120,120", dut.rec_layer.w23, dut.rec_layer.w32); end
    checks++; if ({dut.rec_layer.w01, dut.rec_layer.w10} !== {8'd8, 8'd8}) begin errors++; $display("FAIL learn_b_wa got=%0d,%0d exp=8,8", dut.rec_layer.w01, dut.rec_layer.w10); end
    ext_spike_in = 4'b0000; reward = 1'b0;
    for (int k = 0; k < 30; k++) begin step(); if (char_changed) n_changed++; end
    n = '{0, 0, 0, 0};
    ext_spike_in = 4'b0100;
    for (int k = 0; k < 100; k++) begin
      step();
      if (char_changed) n_changed++;
      for (int j = 0; j < 4; j++) if (rec_spike[j]) n[j]++;
    end
    ext_spike_in = 4'b0000;
    checks++; if (n[2] < 30) begin errors++; $display("FAIL recall_b_n2 got=%0d exp=>=30", n[2]); end
    checks++; if ((n[3] > n[2] + 1) || (n[3] + 1 < n[2])) begin errors++; $display("FAIL recall_b_n3 got=%0d exp=%0d+-1", n[3], n[2]); end
    checks++; if ((n[0] != 0) || (n[1] != 0)) begin errors++; $display("FAIL recall_b_a_silent got=%0d,%0d exp=0,0", n[0], n[1]); end
    checks++; if (char_out !== 8'h42) begin errors++; $display("FAIL learn_b_char got=%h exp=42", char_out); end
    checks++; if (n_changed != 1) begin errors++; $display("FAIL learn_b_changed_pulses got=%0d exp=1", n_changed); end
  endtask

  initial begin
    rst = 1'b1; ext_spike_in = 4'b0000; reward = 1'b0;
    test_reset();
    test_single_neuron();
    test_dopamine();
    test_reset_midrun();
    test_learn_a();
    test_learn_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
